// File: rtl/sram_multiport_ctrl.sv
// -----------------------------------------------------------------------------
// sram_multiport_ctrl
//
// Asynchronous-SRAM controller that lets NUM_CHANNELS independent requesters
// share one CY7C1399B-class pad interface. Each requester has a req/ack
// handshake. The controller arbitrates between them, inserts programmable
// read-access and write-pulse wait states, and adds a setup cycle and a hold
// cycle around every write so the shared data bus turns around cleanly.
//
// Build option:
//   SRAM_ROUND_ROBIN_EN  When defined, arbitration is round-robin: after
//                        channel k is granted, the priority order becomes
//                        k+1, k+2, ..., k. When undefined, arbitration is
//                        fixed priority and the lowest-index requester wins.
//
// Ports:
//   sys_clk       sole clock; all logic runs on its rising edge
//   sys_rst_n     synchronous, active-low reset
//   enable        1 = SRAM powered up; 0 = power down once idle
//   req[N]        per-channel request, held until ack
//   we[N]         per-channel direction: 1 = write, 0 = read
//   addr[N*A]     flattened addresses; channel i at [i*A +: A]
//   wdata[N*D]    flattened write data; channel i at [i*D +: D]
//   ack[N]        one-cycle completion pulse, one-hot or zero
//   rdata[D]      read data, valid in the ack cycle of a read
//   busy          1 whenever the controller is not in IDLE
//   SRAM_DATA     bidirectional pad data bus
//   SRAM_ADDRESS  pad address
//   SRAM_CE/OE/WE active-low pad strobes
// -----------------------------------------------------------------------------
module sram_multiport_ctrl #(
    parameter int NUM_ADDRESS_LINES = 15,
    parameter int DATA_WIDTH        = 8,
    parameter int NUM_CHANNELS      = 2,
    parameter int RD_WAIT_CYCLES    = 2,
    parameter int WR_PULSE_CYCLES   = 2
) (
    input  logic                                      sys_clk,
    input  logic                                      sys_rst_n,
    input  logic                                      enable,
    input  logic [NUM_CHANNELS-1:0]                   req,
    input  logic [NUM_CHANNELS-1:0]                   we,
    input  logic [NUM_CHANNELS*NUM_ADDRESS_LINES-1:0] addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]        wdata,
    output logic [NUM_CHANNELS-1:0]                   ack,
    output logic [DATA_WIDTH-1:0]                     rdata,
    output logic                                      busy,
    inout  wire  [DATA_WIDTH-1:0]                     SRAM_DATA,
    output logic [NUM_ADDRESS_LINES-1:0]              SRAM_ADDRESS,
    output logic                                      SRAM_CE,
    output logic                                      SRAM_OE,
    output logic                                      SRAM_WE
);

    localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_MAX = (RD_WAIT_CYCLES > WR_PULSE_CYCLES) ? RD_WAIT_CYCLES : WR_PULSE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAKE,
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [CH_W-1:0]          ch_lat;
    logic [DATA_WIDTH-1:0]    wdata_lat;
    logic                     drive_en;

    logic                     grant_valid;
    logic [CH_W-1:0]          grant_idx;
    logic [NUM_ADDRESS_LINES-1:0] grant_addr;
    logic [DATA_WIDTH-1:0]    grant_wdata;
    logic                     grant_we;

`ifdef SRAM_ROUND_ROBIN_EN
    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CHANNELS);

    // rr_ptr names the channel with top priority for the next grant.
    logic [CH_W-1:0]          rr_ptr;
    logic [CH_W:0]            cand;
`endif

    // Arbitration. The loop walks the priority order from lowest to highest
    // priority so that the last requester found, which has the highest
    // priority, is the one that wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
`ifdef SRAM_ROUND_ROBIN_EN
        cand = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (req[cand[CH_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[CH_W-1:0];
            end
        end
`else
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(i);
            end
        end
`endif
        grant_addr  = '0;
        grant_wdata = '0;
        grant_we    = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (grant_idx == CH_W'(k)) begin
                grant_addr  = addr[k*NUM_ADDRESS_LINES +: NUM_ADDRESS_LINES];
                grant_wdata = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                grant_we    = we[k];
            end
        end
    end

    // Main controller FSM. Every pad strobe is a register, so the pins
    // cannot glitch. The counter is loaded with (cycles - 1), which means
    // each wait state lasts exactly the programmed number of cycles.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= ST_OFF;
            SRAM_CE      <= 1'b1;
            SRAM_OE      <= 1'b1;
            SRAM_WE      <= 1'b1;
            SRAM_ADDRESS <= '0;
            drive_en     <= 1'b0;
            ack          <= '0;
            rdata        <= '0;
            cnt          <= '0;
            ch_lat       <= '0;
            wdata_lat    <= '0;
`ifdef SRAM_ROUND_ROBIN_EN
            rr_ptr       <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                ST_OFF: begin
                    if (enable) begin
                        state   <= ST_WAKE;
                        SRAM_CE <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    // Power-down takes precedence; pending requests simply
                    // wait until the SRAM is awake again.
                    if (!enable) begin
                        state   <= ST_OFF;
                        SRAM_CE <= 1'b1;
                    end else if (grant_valid) begin
                        ch_lat       <= grant_idx;
                        SRAM_ADDRESS <= grant_addr;
                        wdata_lat    <= grant_wdata;
`ifdef SRAM_ROUND_ROBIN_EN
                        rr_ptr <= (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
`endif
                        if (grant_we) begin
                            state   <= ST_WR_SETUP;
                            SRAM_OE <= 1'b1;
                            SRAM_WE <= 1'b1;
                        end else begin
                            state   <= ST_RD_WAIT;
                            SRAM_OE <= 1'b0;
                            SRAM_WE <= 1'b1;
                            cnt     <= CNT_W'(RD_WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        rdata       <= SRAM_DATA;
                        ack[ch_lat] <= 1'b1;
                        SRAM_OE     <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    // OE has been high for a full cycle, so the SRAM has
                    // released the bus before the controller drives it.
                    state    <= ST_WR_PULSE;
                    SRAM_WE  <= 1'b0;
                    drive_en <= 1'b1;
                    cnt      <= CNT_W'(WR_PULSE_CYCLES - 1);
                end
                ST_WR_PULSE: begin
                    if (cnt == '0) begin
                        state   <= ST_WR_HOLD;
                        SRAM_WE <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    // Data stays on the bus through the WE rising edge for
                    // hold time, and is released here.
                    drive_en    <= 1'b0;
                    ack[ch_lat] <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state    <= ST_OFF;
                    SRAM_CE  <= 1'b1;
                    SRAM_OE  <= 1'b1;
                    SRAM_WE  <= 1'b1;
                    drive_en <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign SRAM_DATA = drive_en ? wdata_lat : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_multiport_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_multiport_ctrl
//
// Directed self-checking bench for sram_multiport_ctrl using the default
// parameters (2 channels, 8-bit data, 15 address lines, 2 read-wait cycles,
// 2 write-pulse cycles). A behavioural asynchronous SRAM sits on the pad
// interface. Inputs change on the falling clock edge and outputs are also
// sampled there, so sampling stays away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_sram_multiport_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        enable;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [29:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    wire  [7:0]  sram_data;
    logic [14:0] sram_address;
    logic        sram_ce;
    logic        sram_oe;
    logic        sram_we;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:32767];

    sram_multiport_ctrl #(
        .NUM_ADDRESS_LINES (15),
        .DATA_WIDTH        (8),
        .NUM_CHANNELS      (2),
        .RD_WAIT_CYCLES    (2),
        .WR_PULSE_CYCLES   (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .enable       (enable),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .busy         (busy),
        .SRAM_DATA    (sram_data),
        .SRAM_ADDRESS (sram_address),
        .SRAM_CE      (sram_ce),
        .SRAM_OE      (sram_oe),
        .SRAM_WE      (sram_we)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural SRAM: drives the bus while selected with OE low and WE
    // high, and captures the bus on the rising edge of WE.
    assign sram_data = (sram_ce == 1'b0 && sram_oe == 1'b0 && sram_we == 1'b1) ? mem[sram_address] : 8'hzz;

    always @(posedge sram_we) begin
        if (sram_ce == 1'b0) begin
            mem[sram_address] = sram_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [14:0] a0, input logic [14:0] a1,
                                 input logic [7:0] d0, input logic [7:0] d1);
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic nextCycle();
        @(negedge sys_clk);
    endtask

    // Moves to the next falling edge at least once, then keeps going until
    // an ack appears or the cycle budget runs out.
    task automatic waitAck(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (ack == 2'b00 && n < 12);
        checkOutput({tag, "_ack_seen"}, 32'(ack != 2'b00), 32'd1);
    endtask

    initial begin
        logic [1:0] expAck;
        logic [7:0] expData;
        logic       ackSeen;

        sys_rst_n = 1'b0;
        enable    = 1'b0;
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        repeat (2) nextCycle();

        checkOutput("rst_ce",    32'(sram_ce),      32'd1);
        checkOutput("rst_oe",    32'(sram_oe),      32'd1);
        checkOutput("rst_we",    32'(sram_we),      32'd1);
        checkOutput("rst_addr",  32'(sram_address), 32'd0);
        checkOutput("rst_ack",   32'(ack),          32'd0);
        checkOutput("rst_rdata", 32'(rdata),        32'd0);
        checkOutput("rst_busy",  32'(busy),         32'd1);

        sys_rst_n = 1'b1;
        enable    = 1'b1;
        nextCycle();
        checkOutput("wake_ce",   32'(sram_ce), 32'd0);
        checkOutput("wake_busy", 32'(busy),    32'd1);
        nextCycle();
        checkOutput("idle_busy", 32'(busy),    32'd0);

        $display("[TB] ch0 write 0x0123 <= 0xA5");
        applyStimulus(2'b01, 2'b01, 15'h0123, 15'h0, 8'hA5, 8'h00);
        nextCycle();
        checkOutput("wr_setup_addr",  32'(sram_address), 32'h0123);
        checkOutput("wr_setup_we",    32'(sram_we),      32'd1);
        checkOutput("wr_setup_bus",   32'(sram_data === 8'hA5), 32'd0);
        checkOutput("wr_setup_busy",  32'(busy),         32'd1);
        nextCycle();
        checkOutput("wr_pulse1_we",   32'(sram_we),   32'd0);
        checkOutput("wr_pulse1_oe",   32'(sram_oe),   32'd1);
        checkOutput("wr_pulse1_bus",  32'(sram_data), 32'hA5);
        nextCycle();
        checkOutput("wr_pulse2_we",   32'(sram_we),   32'd0);
        checkOutput("wr_pulse2_bus",  32'(sram_data), 32'hA5);
        checkOutput("wr_pulse2_ack",  32'(ack),       32'd0);
        nextCycle();
        checkOutput("wr_hold_we",     32'(sram_we),   32'd1);
        checkOutput("wr_hold_bus",    32'(sram_data), 32'hA5);
        checkOutput("wr_hold_ack",    32'(ack),       32'd0);
        nextCycle();
        checkOutput("wr_ack",         32'(ack),       32'b01);
        checkOutput("wr_ack_busy",    32'(busy),      32'd0);
        checkOutput("wr_ack_bus",     32'(sram_data === 8'hA5), 32'd0);
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("wr_ack_clear",   32'(ack),       32'd0);

        $display("[TB] ch0 read 0x0123");
        applyStimulus(2'b01, 2'b00, 15'h0123, 15'h0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("rd_e0_oe",   32'(sram_oe),      32'd0);
        checkOutput("rd_e0_we",   32'(sram_we),      32'd1);
        checkOutput("rd_e0_addr", 32'(sram_address), 32'h0123);
        checkOutput("rd_e0_ack",  32'(ack),          32'd0);
        nextCycle();
        checkOutput("rd_e1_ack",  32'(ack),          32'd0);
        nextCycle();
        checkOutput("rd_ack",     32'(ack),          32'b01);
        checkOutput("rd_rdata",   32'(rdata),        32'hA5);
        checkOutput("rd_ack_oe",  32'(sram_oe),      32'd1);
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("rd_ack_clear", 32'(ack),        32'd0);

        $display("[TB] ch1 write 0x0200 <= 0x5A");
        applyStimulus(2'b10, 2'b10, 15'h0, 15'h0200, 8'h00, 8'h5A);
        waitAck("ch1_wr");
        checkOutput("ch1_wr_ack", 32'(ack), 32'b10);
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        nextCycle();

        $display("[TB] both channels reading continuously");
        applyStimulus(2'b11, 2'b00, 15'h0123, 15'h0200, 8'h00, 8'h00);
        for (int t = 0; t < 4; t++) begin
`ifdef SRAM_ROUND_ROBIN_EN
            expAck = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
            expAck = 2'b01;
`endif
            expData = (expAck == 2'b01) ? 8'hA5 : 8'h5A;
            waitAck($sformatf("contend%0d", t));
            checkOutput($sformatf("contend%0d_ack", t),   32'(ack),   32'(expAck));
            checkOutput($sformatf("contend%0d_rdata", t), 32'(rdata), 32'(expData));
        end
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("contend_ack_clear", 32'(ack), 32'd0);

        $display("[TB] enable dropped during a ch1 write");
        applyStimulus(2'b10, 2'b10, 15'h0, 15'h0300, 8'h00, 8'h77);
        nextCycle();
        nextCycle();
        checkOutput("pd_pulse_we", 32'(sram_we), 32'd0);
        enable = 1'b0;
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("pd_ack",      32'(ack),     32'b10);
        checkOutput("pd_ack_ce",   32'(sram_ce), 32'd0);
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("pd_off_ce",   32'(sram_ce), 32'd1);
        checkOutput("pd_off_busy", 32'(busy),    32'd1);

        applyStimulus(2'b01, 2'b00, 15'h0300, 15'h0, 8'h00, 8'h00);
        for (int t = 0; t < 3; t++) begin
            nextCycle();
            checkOutput($sformatf("off_pending%0d_ack", t), 32'(ack),     32'd0);
            checkOutput($sformatf("off_pending%0d_ce", t),  32'(sram_ce), 32'd1);
        end
        enable = 1'b1;
        nextCycle();
        checkOutput("rewake_ce",   32'(sram_ce), 32'd0);
        checkOutput("rewake_ack",  32'(ack),     32'd0);
        nextCycle();
        checkOutput("reidle_busy", 32'(busy),    32'd0);
        checkOutput("reidle_ack",  32'(ack),     32'd0);
        nextCycle();
        checkOutput("pend_rd_oe",  32'(sram_oe), 32'd0);
        nextCycle();
        nextCycle();
        checkOutput("pend_rd_ack",   32'(ack),   32'b01);
        checkOutput("pend_rd_rdata", 32'(rdata), 32'h77);
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        nextCycle();

        $display("[TB] reset during RD_WAIT");
        applyStimulus(2'b01, 2'b00, 15'h0123, 15'h0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("abort_rd_oe", 32'(sram_oe), 32'd0);
        sys_rst_n = 1'b0;
        applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("abort_ce",    32'(sram_ce), 32'd1);
        checkOutput("abort_oe",    32'(sram_oe), 32'd1);
        checkOutput("abort_we",    32'(sram_we), 32'd1);
        checkOutput("abort_ack",   32'(ack),     32'd0);
        checkOutput("abort_rdata", 32'(rdata),   32'd0);
        checkOutput("abort_busy",  32'(busy),    32'd1);
        sys_rst_n = 1'b1;
        ackSeen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            nextCycle();
            if (ack != 2'b00) begin
                ackSeen = 1'b1;
            end
        end
        checkOutput("abort_no_late_ack", 32'(ackSeen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
